// File: rtl/ansi_escape_parser.sv
// ANSI/VT byte-stream parser: C0 controls, printables, ESC and CSI sequences.
// Optional `?` private-prefix handling is enabled by defining PARSER_PRIVATE_MODE_EN.
package ansi_escape_parser_pkg;
  typedef enum logic [4:0] {
    INPUT,
    BACKSPACE,
    TAB,
    LINEFEED,
    CARRIAGE_RETURN,
    RESET_TERM,
    REVERSE_INDEX,
    SAVE_CURSOR,
    RESTORE_CURSOR,
    CURSOR_UP,
    CURSOR_DOWN,
    CURSOR_FORWARD,
    CURSOR_BACK,
    CURSOR_POSITION,
    ERASE_DISPLAY,
    ERASE_LINE,
    SET_ATTRIBUTE,
    SET_MODE,
    RESET_MODE
  } CommandsType;
endpackage

module ansi_escape_parser
  import ansi_escape_parser_pkg::*;
#(
  parameter int MAX_PARAMS  = 4,
  parameter int PARAM_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  dataValid,
  input  logic [7:0]                            data,
  output logic                                  dataReady,
  output logic                                  commandReady,
  input  logic                                  commandAck,
  output CommandsType                           commandType,
  // param = {Pprivate, Pcount[3:0], Pn[MAX_PARAMS-1] .. Pn[0], Pchar[7:0]}
  output logic [8+MAX_PARAMS*PARAM_WIDTH+4:0]   param
);

  localparam int IW = $clog2(MAX_PARAMS + 1);
  localparam int CW = PARAM_WIDTH + 4;

  typedef enum logic [1:0] {
    ST_GROUND,
    ST_ESCAPE,
    ST_CSI_PARAM,
    ST_CSI_IGNORE
  } state_t;

  state_t                 state_q, state_d;
  logic                   byte_valid_q, byte_valid_d;
  logic [7:0]             byte_q, byte_d;
  logic                   cmd_ready_q, cmd_ready_d;
  CommandsType            cmd_type_q, cmd_type_d;
  logic [7:0]             pchar_q, pchar_d;
  logic [PARAM_WIDTH-1:0] pn_q [MAX_PARAMS];
  logic [PARAM_WIDTH-1:0] pn_d [MAX_PARAMS];
  logic [3:0]             pcount_q, pcount_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   pprivate_q;
`ifdef PARSER_PRIVATE_MODE_EN
  logic                   pprivate_d;
  logic                   first_q, first_d;
`endif

  logic                   emit;
  CommandsType            emit_type;
  logic [CW-1:0]          acc;
  logic [7:0]             b;

  assign b = byte_q;

  always_comb begin
    state_d      = state_q;
    byte_valid_d = byte_valid_q;
    byte_d       = byte_q;
    cmd_ready_d  = cmd_ready_q;
    cmd_type_d   = cmd_type_q;
    pchar_d      = pchar_q;
    pn_d         = pn_q;
    pcount_d     = pcount_q;
    idx_d        = idx_q;
`ifdef PARSER_PRIVATE_MODE_EN
    pprivate_d   = pprivate_q;
    first_d      = first_q;
`endif
    emit         = 1'b0;
    emit_type    = INPUT;
    acc          = '0;

    if (cmd_ready_q && commandAck) cmd_ready_d = 1'b0;

    // One-byte input stage; it only drains while no command is pending.
    if (!cmd_ready_q) begin
      byte_valid_d = dataValid;
      if (dataValid) byte_d = data;
    end

    if (byte_valid_q && !cmd_ready_q) begin
      if (state_q == ST_GROUND) begin
        if (b >= 8'h20 && b <= 8'h7E) begin
          emit = 1'b1;
          emit_type = INPUT;
        end else begin
          case (b)
            8'h08:               begin emit = 1'b1; emit_type = BACKSPACE;       end
            8'h09:               begin emit = 1'b1; emit_type = TAB;             end
            8'h0A, 8'h0B, 8'h0C: begin emit = 1'b1; emit_type = LINEFEED;        end
            8'h0D:               begin emit = 1'b1; emit_type = CARRIAGE_RETURN; end
            8'h1B:               state_d = ST_ESCAPE;
            default: ;
          endcase
        end
      end else if (b < 8'h20) begin
        if (b == 8'h18 || b == 8'h1A) state_d = ST_GROUND;
        else if (b == 8'h1B)          state_d = ST_ESCAPE;
      end else begin
        case (state_q)
          ST_ESCAPE: begin
            state_d = ST_GROUND;
            case (b)
              "[": begin
                state_d  = ST_CSI_PARAM;
                for (int unsigned i = 0; i < MAX_PARAMS; i++) pn_d[i] = '0;
                pcount_d = '0;
                idx_d    = '0;
`ifdef PARSER_PRIVATE_MODE_EN
                pprivate_d = 1'b0;
                first_d    = 1'b1;
`endif
              end
              "c":     begin emit = 1'b1; emit_type = RESET_TERM;     end
              "D":     begin emit = 1'b1; emit_type = LINEFEED;       end
              "M":     begin emit = 1'b1; emit_type = REVERSE_INDEX;  end
              "7":     begin emit = 1'b1; emit_type = SAVE_CURSOR;    end
              "8":     begin emit = 1'b1; emit_type = RESTORE_CURSOR; end
              default: ;
            endcase
          end
          ST_CSI_PARAM: begin
`ifdef PARSER_PRIVATE_MODE_EN
            first_d = 1'b0;
`endif
            if (b >= "0" && b <= "9") begin
              if (idx_q < IW'(MAX_PARAMS)) begin
                for (int unsigned i = 0; i < MAX_PARAMS; i++) begin
                  if (IW'(i) == idx_q) begin
                    acc = CW'(pn_q[i]) * CW'(10) + CW'(b[3:0]);
                    pn_d[i] = (acc > CW'({PARAM_WIDTH{1'b1}})) ? '1 : acc[PARAM_WIDTH-1:0];
                  end
                end
                if (pcount_q < 4'(idx_q) + 4'd1) pcount_d = 4'(idx_q) + 4'd1;
              end
            end else if (b == ";") begin
              if (idx_q < IW'(MAX_PARAMS)) idx_d = idx_q + IW'(1);
              pcount_d = (4'(idx_q) + 4'd2 < 4'(MAX_PARAMS)) ? 4'(idx_q) + 4'd2 : 4'(MAX_PARAMS);
            end else if (b == "?") begin
`ifdef PARSER_PRIVATE_MODE_EN
              if (first_q) pprivate_d = 1'b1;
              else         state_d    = ST_CSI_IGNORE;
`else
              state_d = ST_CSI_IGNORE;
`endif
            end else if (b >= 8'h40 && b <= 8'h7E) begin
              state_d = ST_GROUND;
              emit    = 1'b1;
              case (b)
                "A":      emit_type = CURSOR_UP;
                "B":      emit_type = CURSOR_DOWN;
                "C":      emit_type = CURSOR_FORWARD;
                "D":      emit_type = CURSOR_BACK;
                "H", "f": emit_type = CURSOR_POSITION;
                "J":      emit_type = ERASE_DISPLAY;
                "K":      emit_type = ERASE_LINE;
                "m":      emit_type = SET_ATTRIBUTE;
                "h":      emit_type = SET_MODE;
                "l":      emit_type = RESET_MODE;
                default:  emit      = 1'b0;
              endcase
            end else if (b < 8'h40) begin
              // Remaining sub-0x40 bytes here are intermediates, ':' and '<'..'>'.
              state_d = ST_CSI_IGNORE;
            end
          end
          ST_CSI_IGNORE: begin
            if (b >= 8'h40 && b <= 8'h7E) state_d = ST_GROUND;
          end
          default: state_d = ST_GROUND;
        endcase
      end

      if (emit) begin
        cmd_ready_d = 1'b1;
        cmd_type_d  = emit_type;
        pchar_d     = b;
        state_d     = ST_GROUND;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_GROUND;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      cmd_ready_q  <= 1'b0;
      cmd_type_q   <= INPUT;
      pchar_q      <= '0;
      for (int unsigned i = 0; i < MAX_PARAMS; i++) pn_q[i] <= '0;
      pcount_q     <= '0;
      idx_q        <= '0;
`ifdef PARSER_PRIVATE_MODE_EN
      pprivate_q   <= 1'b0;
      first_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      cmd_ready_q  <= cmd_ready_d;
      cmd_type_q   <= cmd_type_d;
      pchar_q      <= pchar_d;
      pn_q         <= pn_d;
      pcount_q     <= pcount_d;
      idx_q        <= idx_d;
`ifdef PARSER_PRIVATE_MODE_EN
      pprivate_q   <= pprivate_d;
      first_q      <= first_d;
`endif
    end
  end

`ifndef PARSER_PRIVATE_MODE_EN
  assign pprivate_q = 1'b0;
`endif

  assign dataReady    = !cmd_ready_q;
  assign commandReady = cmd_ready_q;
  assign commandType  = cmd_type_q;

  assign param[7:0] = pchar_q;
  for (genvar g = 0; g < MAX_PARAMS; g++) begin : g_pn
    assign param[8 + g*PARAM_WIDTH +: PARAM_WIDTH] = pn_q[g];
  end
  assign param[8 + MAX_PARAMS*PARAM_WIDTH +: 4] = pcount_q;
  assign param[8 + MAX_PARAMS*PARAM_WIDTH + 4]  = pprivate_q;

endmodule

// File: tb/tb_ansi_escape_parser.sv
// Scoreboard bench for ansi_escape_parser (default MAX_PARAMS=4, PARAM_WIDTH=8).
module tb_ansi_escape_parser;
  import ansi_escape_parser_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dataValid;
  logic [7:0]  data;
  logic        dataReady;
  logic        commandReady;
  logic        commandAck;
  CommandsType commandType;
  logic [44:0] param;

  ansi_escape_parser #(.MAX_PARAMS(4), .PARAM_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .dataValid(dataValid), .data(data), .dataReady(dataReady),
    .commandReady(commandReady), .commandAck(commandAck), .commandType(commandType),
    .param(param)
  );

  always #5 clk = ~clk;

  typedef logic [49:0] cmd_t;
  localparam logic [7:0] ESC = 8'h1B;

  int   total = 0;
  int   bad   = 0;
  cmd_t exp_q[$];
  cmd_t obs_q[$];

  logic [7:0] m_pn [4];
  logic [3:0] m_pcount;
  logic       m_priv;

  function automatic void setp(input int p0, input int p1, input int p2, input int p3,
                               input int cnt, input bit pr);
    m_pn[0] = 8'(p0); m_pn[1] = 8'(p1); m_pn[2] = 8'(p2); m_pn[3] = 8'(p3);
    m_pcount = 4'(cnt);
    m_priv   = pr;
  endfunction

  function automatic cmd_t mk(input CommandsType t, input logic [7:0] ch);
    return {t, m_priv, m_pcount, m_pn[3], m_pn[2], m_pn[1], m_pn[0], ch};
  endfunction

  // Capture each newly raised command.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) prev = 1'b0;
      else begin
        if (commandReady && !prev) obs_q.push_back({commandType, param});
        prev = commandReady;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    dataValid = 1'b1;
    data      = b;
    while (!dataReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!dataReady) begin
      total++; bad++;
      $display("FAIL send_timeout byte=%02h dataReady=%b required=1", b, dataReady);
    end
    @(negedge clk);
    dataValid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1; dataValid = 1'b0; data = '0; commandAck = 1'b1;
    setp(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (commandReady !== 1'b0) begin bad++; $display("FAIL reset_cmdready got=%b want=0", commandReady); end
    total++; if (dataReady !== 1'b1) begin bad++; $display("FAIL reset_dataready got=%b want=1", dataReady); end
    total++; if (commandType !== INPUT) begin bad++; $display("FAIL reset_type got=%0d want=%0d", commandType, INPUT); end
    total++; if (param !== '0) begin bad++; $display("FAIL reset_param got=%h want=0", param); end
  endtask

  task automatic test_basic;
    cmd_t e, o;
    commandAck = 1'b1;
    exp_q.push_back(mk(INPUT, 8'h41));
    exp_q.push_back(mk(CARRIAGE_RETURN, 8'h0D));
    dataValid = 1'b1; data = 8'h41;
    @(posedge clk); #1;
    total++; if (commandReady !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", commandReady); end
    data = 8'h0D;
    @(posedge clk); #1;
    dataValid = 1'b0;
    total++; if (commandReady !== 1'b1) begin bad++; $display("FAIL latency_raise got=%b want=1", commandReady); end
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL basic_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_csi_params;
    cmd_t e, o;
    send(ESC); send_str("[12;34H");
    setp(12, 34, 0, 0, 2, 0); exp_q.push_back(mk(CURSOR_POSITION, "H"));
    send(ESC); send_str("[999A");
    setp(255, 0, 0, 0, 1, 0); exp_q.push_back(mk(CURSOR_UP, "A"));
    send(ESC); send_str("[1;2;3;4;5;6m");
    setp(1, 2, 3, 4, 4, 0); exp_q.push_back(mk(SET_ATTRIBUTE, "m"));
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL csi_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL csi_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_controls;
    cmd_t e, o;
    send(8'h08); exp_q.push_back(mk(BACKSPACE, 8'h08));
    send(8'h09); exp_q.push_back(mk(TAB, 8'h09));
    send(8'h0B); exp_q.push_back(mk(LINEFEED, 8'h0B));
    send(8'h00); send(8'h7F);
    send(ESC); send("c"); exp_q.push_back(mk(RESET_TERM, "c"));
    send(ESC); send("D"); exp_q.push_back(mk(LINEFEED, "D"));
    send(ESC); send("M"); exp_q.push_back(mk(REVERSE_INDEX, "M"));
    send(ESC); send(ESC); send("7"); exp_q.push_back(mk(SAVE_CURSOR, "7"));
    send(ESC); send("8"); exp_q.push_back(mk(RESTORE_CURSOR, "8"));
    send(ESC); send("q");
    send(8'h0D); exp_q.push_back(mk(CARRIAGE_RETURN, 8'h0D));
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ctrl_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL ctrl_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_csi_misc;
    cmd_t e, o;
    send(ESC); send_str("[3"); send(8'h07); send("B");
    setp(3, 0, 0, 0, 1, 0); exp_q.push_back(mk(CURSOR_DOWN, "B"));
    send(ESC); send_str("[2"); send(8'h18); send("Z");
    setp(2, 0, 0, 0, 1, 0); exp_q.push_back(mk(INPUT, "Z"));
    send(ESC); send_str("[1!qY");
    setp(1, 0, 0, 0, 1, 0); exp_q.push_back(mk(INPUT, "Y"));
    send(ESC); send_str("[;7f");
    setp(0, 7, 0, 0, 2, 0); exp_q.push_back(mk(CURSOR_POSITION, "f"));
    send(ESC); send_str("[5xW");
    setp(5, 0, 0, 0, 1, 0); exp_q.push_back(mk(INPUT, "W"));
    send(ESC); send_str("[K");
    setp(0, 0, 0, 0, 0, 0); exp_q.push_back(mk(ERASE_LINE, "K"));
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL misc_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL misc_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_private;
    cmd_t e, o;
    send(ESC); send_str("[?25l");
`ifdef PARSER_PRIVATE_MODE_EN
    setp(25, 0, 0, 0, 1, 1); exp_q.push_back(mk(RESET_MODE, "l"));
`else
    setp(0, 0, 0, 0, 0, 0);
`endif
    send("X"); exp_q.push_back(mk(INPUT, 8'h58));
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL private_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL private_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_hold;
    cmd_t e, o, snap;
    int n = 0;
    commandAck = 1'b0;
    exp_q.push_back(mk(INPUT, "A"));
    exp_q.push_back(mk(INPUT, "B"));
    exp_q.push_back(mk(INPUT, "C"));
    send("A"); send("B");
    dataValid = 1'b1; data = "C";
    while (!commandReady && n < 20) begin @(negedge clk); n++; end
    total++; if (commandReady !== 1'b1) begin bad++; $display("FAIL hold_raise got=%b want=1", commandReady); end
    snap = {commandType, param};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (commandReady !== 1'b1 || dataReady !== 1'b0 || {commandType, param} !== snap) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got ready=%b dready=%b out=%h want ready=1 dready=0 out=%h",
                 i, commandReady, dataReady, {commandType, param}, snap);
      end
    end
    commandAck = 1'b1;
    @(negedge clk);
    total++; if (commandReady !== 1'b0) begin bad++; $display("FAIL hold_release got=%b want=0", commandReady); end
    send("C");
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL hold_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL hold_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    cmd_t e, o;
    send(ESC); send_str("[3");
    #2 rst = 1'b1;
    #1;
    total++; if (commandReady !== 1'b0 || dataReady !== 1'b1 || param !== '0) begin
      bad++; $display("FAIL rst_mid got ready=%b dready=%b param=%h want 0 1 0", commandReady, dataReady, param);
    end
    @(negedge clk);
    rst = 1'b0;
    setp(0, 0, 0, 0, 0, 0);
    send("J"); exp_q.push_back(mk(INPUT, 8'h4A));
    repeat (12) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL rstmid_cmd got=%h want=%h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_csi_params();
    test_controls();
    test_csi_misc();
    test_private();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ansi_escape_parser.md
# ansi_escape_parser

Byte-stream front end of the console parser. It consumes received characters one byte at a time and decodes C0 controls, printable characters, ESC sequences and CSI sequences with numeric parameters. It emits one decoded command per sequence to the text-editing stage through a held valid / acknowledge handshake. It sits between the UART receive FIFO and the text editor.

## Interface
- `MAX_PARAMS`, default 4: number of CSI numeric parameters stored.
- `PARAM_WIDTH`, default 8: width of each stored parameter.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `dataValid` in 1: `data` holds a byte.
- `data` in 8: received byte.
- `dataReady` out 1: byte accepted when `dataValid & dataReady`; equals `!commandReady`.
- `commandReady` out 1: command valid; held until acknowledged.
- `commandAck` in 1: editor consumed the command.
- `commandType` out CommandsType: decoded command.
- `param` out Param_t:
  - `Pchar` [7:0]: byte that produced the command.
  - `Pn[MAX_PARAMS]` × PARAM_WIDTH: numeric parameters.
  - `Pcount` [3:0]: number of parameters.
  - `Pprivate` 1: `?` prefix was seen.

## Operation
- States: Ground, Escape, CsiParam, CsiIgnore.
- **Ground**, per accepted byte:
  - 0x20–0x7E → INPUT, `Pchar` = byte.
  - 0x08 → BACKSPACE; 0x09 → TAB; 0x0A/0x0B/0x0C → LINEFEED; 0x0D → CARRIAGE_RETURN.
  - 0x1B → Escape.
  - All other bytes are dropped.
- **Escape**:
  - `[` → clear `Pn`, `Pcount`, `Pprivate`, index; go to CsiParam.
  - `c` → RESET_TERM.
  - `D` → LINEFEED.
  - `M` → REVERSE_INDEX.
  - `7` → SAVE_CURSOR; `8` → RESTORE_CURSOR.
  - 0x1B → stay in Escape.
  - Any other byte → Ground, no command.
- **CsiParam**:
  - Digit: `Pn[idx] = min(Pn[idx]*10 + d, 2^PARAM_WIDTH−1)`. Compute at PARAM_WIDTH+4 bits, then saturate. Set `Pcount = max(Pcount, idx+1)`.
  - `;`: increment `idx`, saturating at MAX_PARAMS. Set `Pcount = min(idx+2, MAX_PARAMS)`. Digits arriving while `idx == MAX_PARAMS` are discarded.
  - `?` as first byte: set `Pprivate`. `?` anywhere else → CsiIgnore.
  - Final bytes:
    - `A` → CURSOR_UP; `B` → CURSOR_DOWN; `C` → CURSOR_FORWARD; `D` → CURSOR_BACK.
    - `H` or `f` → CURSOR_POSITION.
    - `J` → ERASE_DISPLAY; `K` → ERASE_LINE.
    - `m` → SET_ATTRIBUTE.
    - `h` → SET_MODE; `l` → RESET_MODE.
    - After any final byte, return to Ground.
  - Other 0x40–0x7E → Ground, no command.
  - 0x20–0x2F, 0x3A, 0x3C–0x3E → CsiIgnore.
- **CsiIgnore**: discard bytes until 0x40–0x7E, then go to Ground with no command.
- In Escape, CsiParam and CsiIgnore:
  - 0x18 or 0x1A → Ground, no command.
  - 0x1B → Escape; parameters are cleared on the next `[`.
  - Other C0 bytes are dropped with no state change.
- Empty parameter fields read as 0; defaulting (0 → 1, etc.) belongs to the editor.
- The `Pn`, `Pcount` and `Pprivate` fields of `param` hold their values while `commandReady` is high.

## Timing
- Command latency: the byte accepted at edge t raises `commandReady` after edge t+1 (registered output); `commandType` and `param` are valid in that same cycle.
- Holding: `commandReady` stays high until a cycle with `commandAck`; it is low after the following edge. `dataReady` is low throughout, so bytes are back-pressured and none are lost.
- `commandAck` while `commandReady` is low is ignored.
- Throughput: one byte per cycle when no command is pending; at most one command per two cycles with immediate ack.
- Reset (asynchronous, any state):
  - State = Ground, `commandReady` = 0, `dataReady` = 1.
  - `commandType` = INPUT; all `param` fields = 0.
  - A sequence in progress is abandoned.

## Configuration
- `PARSER_PRIVATE_MODE_EN` defined: `?` prefix handling as above; `Pprivate` is reported with SET_MODE / RESET_MODE and all other finals.
- Undefined: `?` in CsiParam → CsiIgnore, so the whole sequence is dropped; `Pprivate` is tied to 0.

## Test plan
- Bytes 0x41, 0x0D, ack each cycle → INPUT with `Pchar` = 0x41, then CARRIAGE_RETURN; one command each, no byte lost.
- `ESC [ 1 2 ; 3 4 H` → CURSOR_POSITION, `Pn[0]` = 12, `Pn[1]` = 34, `Pcount` = 2.
- `ESC [ 9 9 9 A` → CURSOR_UP, `Pn[0]` = 255 (saturated), `Pcount` = 1.
- `ESC [ 1;2;3;4;5;6 m` → SET_ATTRIBUTE, `Pn` = 1, 2, 3, 4, `Pcount` = 4.
- `ESC [ ? 2 5 l`:
  - With the macro: RESET_MODE, `Pprivate` = 1, `Pn[0]` = 25.
  - Without it: no command.
  - In both cases, a following `X` yields INPUT 0x58.
- `commandAck` held low 5 cycles while `dataValid` stays high → `commandReady` and all outputs stable, `dataReady` = 0. Assert `rst` mid-`ESC [ 3` → Ground, `commandReady` = 0. Then `J` → INPUT 0x4A.
